reg_bank_wb: RTL and testbench
==============================

# reg_bank_wb

Parametrised architectural register bank with merged write-back for the accumulator processor. It replaces the fixed ACC/X/Y/SP/SR/BR/AUX write logic with an indexed bank that arbitrates ALU, memory, input and transfer writes per destination, and adds SP push/pop with bound checks. It also provides a single-cycle shadow save/restore of the whole bank, plus sticky error flags. It sits between the control unit/datapath muxes and every consumer of architectural registers.

## Interface
Parameters:
- DATA_W, 32, register width
- NUM_REGS, 8, bank depth (minimum 7)
- IDX_W, $clog2(NUM_REGS), index width
- SP_RESET, 9497, SP reset value and stack top
- SP_MIN, 0, lowest legal SP
- FLAG_W, 3, width of SR flag field SR[FLAG_W-1:0]
- PFF_BIT, 3, process-finish flag bit in SR

Ports:
- clock  in  1  clock
- reset  in  1  reset; synchronous, active-high
- alu_we / alu_dst / alu_data  in  1 / IDX_W / DATA_W  ALU result write
- mem_we / mem_dst / mem_data  in  1 / IDX_W / DATA_W  memory load write
- in_we / in_dst / in_data  in  1 / IDX_W / DATA_W  input-instruction write
- xfer_en / xfer_src / xfer_dst  in  1 / IDX_W / IDX_W  register-to-register transfer
- sr_flags_we / sr_flags  in  1 / FLAG_W  ALU flag update
- proc_finish  in  1  set SR[PFF_BIT]
- br_clr  in  1  clear BR
- sp_op  in  2  00 none, 01 push (SP-1), 10 pop (SP+1), 11 ignored
- ctx_save / ctx_restore  in  1 / 1  shadow bank copy
- rd_addr_a / rd_addr_b  in  IDX_W  read addresses
- rd_data_a / rd_data_b  out  DATA_W  combinational reads of current bank
- acc / sp / sr  out  DATA_W  direct taps of indices 0, 3, 4
- pff  out  1  SR[PFF_BIT]
- conflict_err / sp_ovf / sp_unf  out  1  sticky error flags
- err_clr  in  1  clear sticky flags

## Operation
- Fixed indices: 0 ACC, 1 X, 2 Y, 3 SP, 4 SR, 5 BR, 6 AUX, 7 and above general-purpose.
- Per-destination priority, highest first: xfer > mem > in > alu. Exactly one write is committed per destination per cycle.
- Two or more enabled sources on the same destination in the same cycle: the highest-priority source wins and conflict_err is set.
- A transfer reads the source value from before the edge. Swaps across two transfer cycles are therefore well-defined.
- SR next-value rule:
  - If a full write targets SR, SR takes that data.
  - Otherwise, if sr_flags_we is asserted, SR[FLAG_W-1:0] takes sr_flags.
  - In both cases, proc_finish then ORs 1 into SR[PFF_BIT].
- BR: a source write takes priority over br_clr. With br_clr alone, BR goes to 0.
- SP operations:
  - Push at SP == SP_MIN: SP holds and sp_ovf is set.
  - Pop at SP == SP_RESET: SP holds and sp_unf is set.
  - sp_op together with any source write to SP: the source write wins, sp_op is dropped, and conflict_err is set.
- ctx_save: the shadow bank captures all pre-edge register values. Writes on the same edge still commit to the live bank.
- ctx_restore: the live bank loads from the shadow bank and overrides all same-cycle writes, sp_op and flag updates.
- ctx_save and ctx_restore together: the two banks swap.
- Out-of-range index (>= NUM_REGS): the write is ignored and the read returns 0.
- Sticky flags: set-dominant over err_clr in the same cycle.

## Timing
- All state updates on posedge clock. A write presented in cycle N is visible on rd_data, acc, sp and sr after edge N. There is no pipeline or forwarding.
- Reset has priority over everything. Reset values:
  - SP = SP_RESET; all other live registers 0.
  - Shadow bank 0.
  - conflict_err, sp_ovf, sp_unf all 0.
- Reset mid-operation discards every same-cycle request, including ctx_restore.
- SP arithmetic is modulo 2^DATA_W, but the bound checks prevent wrap within [SP_MIN, SP_RESET].

## Structure
- Package reg_bank_pkg holds:
  - index constants IDX_ACC … IDX_AUX
  - the sp_op encodings SP_NONE/SP_PUSH/SP_POP
  - the source-priority ordering
- Sub-module reg_write_arb: per-destination priority mux plus conflict detect. It is instantiated once per register via generate.

## Test plan
- Reset, then alu_we=1 with alu_dst=1 and data 0x55 -> X=0x55 after one edge. Reset -> X=0, SP=9497.
- Same cycle: mem_we to ACC with 0xA and alu_we to ACC with 0xB -> ACC=0xA, conflict_err=1. Then err_clr -> 0.
- SP=SP_MIN=0, sp_op=01 -> SP stays 0, sp_ovf=1. From reset, sp_op=10 -> SP=9497, sp_unf=1. Push then pop -> 9496, then 9497.
- SR=0: sr_flags_we=1 with sr_flags=3'b101 and proc_finish=1 -> SR=0x0D, pff=1. A full SR write of 0 with proc_finish=1 -> SR=0x08.
- X=5, ctx_save; then X<=9; then ctx_restore with a same-cycle alu write to X -> X=5.
- xfer ACC->X and xfer X->ACC on consecutive cycles with ACC=1, X=2 -> X=1, then ACC=1. Also: a write to index NUM_REGS is ignored and rd_data=0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants for the write-back register bank: architectural indices,
// stack-pointer operation codes and the write-source priority order.
package reg_bank_pkg;

    localparam int IDX_ACC = 0;
    localparam int IDX_X   = 1;
    localparam int IDX_Y   = 2;
    localparam int IDX_SP  = 3;
    localparam int IDX_SR  = 4;
    localparam int IDX_BR  = 5;
    localparam int IDX_AUX = 6;

    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10,
        SP_RSVD = 2'b11
    } sp_op_e;

    // A larger encoding wins when several sources target the same register.
    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_IN   = 2'd1,
        SRC_MEM  = 2'd2,
        SRC_XFER = 2'd3
    } src_e;

    localparam int NUM_SRC = 4;

endpackage

// File: rtl/reg_write_arb.sv
// Write arbiter for one bank entry: selects the highest-priority source that
// targets this index and flags when more than one source did.
module reg_write_arb
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3,
    parameter int MY_IDX = 0
) (
    input  logic              alu_we_i,
    input  logic [IDX_W-1:0]  alu_dst_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              mem_we_i,
    input  logic [IDX_W-1:0]  mem_dst_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              in_we_i,
    input  logic [IDX_W-1:0]  in_dst_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              xfer_en_i,
    input  logic [IDX_W-1:0]  xfer_dst_i,
    input  logic [DATA_W-1:0] xfer_data_i,
    output logic              wr_en_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              conflict_o
);

    localparam logic [IDX_W-1:0] MY = IDX_W'(MY_IDX);

    logic [NUM_SRC-1:0] hit;
    logic [DATA_W-1:0]  src_data [NUM_SRC];

    always_comb begin
        hit                = '0;
        hit[SRC_ALU]       = alu_we_i  && (alu_dst_i  == MY);
        hit[SRC_IN]        = in_we_i   && (in_dst_i   == MY);
        hit[SRC_MEM]       = mem_we_i  && (mem_dst_i  == MY);
        hit[SRC_XFER]      = xfer_en_i && (xfer_dst_i == MY);
        src_data[SRC_ALU]  = alu_data_i;
        src_data[SRC_IN]   = in_data_i;
        src_data[SRC_MEM]  = mem_data_i;
        src_data[SRC_XFER] = xfer_data_i;
        wr_data_o          = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (hit[s]) wr_data_o = src_data[s];
        end
    end

    assign wr_en_o    = |hit;
    assign conflict_o = |(hit & (hit - NUM_SRC'(1)));

endmodule

// File: rtl/reg_bank_wb.sv
// Architectural register bank with merged write-back, SP push/pop with bound
// checks, single-cycle shadow save/restore and sticky error flags.
module reg_bank_wb
    import reg_bank_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          NUM_REGS = 8,
    parameter int          IDX_W    = $clog2(NUM_REGS),
    parameter int unsigned SP_RESET = 9497,
    parameter int unsigned SP_MIN   = 0,
    parameter int          FLAG_W   = 3,
    parameter int          PFF_BIT  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_we,
    input  logic [IDX_W-1:0]  alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_we,
    input  logic [IDX_W-1:0]  mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              in_we,
    input  logic [IDX_W-1:0]  in_dst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              xfer_en,
    input  logic [IDX_W-1:0]  xfer_src,
    input  logic [IDX_W-1:0]  xfer_dst,
    input  logic              sr_flags_we,
    input  logic [FLAG_W-1:0] sr_flags,
    input  logic              proc_finish,
    input  logic              br_clr,
    input  logic [1:0]        sp_op,
    input  logic              ctx_save,
    input  logic              ctx_restore,
    input  logic [IDX_W-1:0]  rd_addr_a,
    input  logic [IDX_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] sp,
    output logic [DATA_W-1:0] sr,
    output logic              pff,
    output logic              conflict_err,
    output logic              sp_ovf,
    output logic              sp_unf,
    input  logic              err_clr
);

    localparam logic [DATA_W-1:0] SP_TOP = DATA_W'(SP_RESET);
    localparam logic [DATA_W-1:0] SP_BOT = DATA_W'(SP_MIN);

    logic [DATA_W-1:0]   live_q   [NUM_REGS];
    logic [DATA_W-1:0]   live_d   [NUM_REGS];
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [DATA_W-1:0]   shadow_d [NUM_REGS];
    logic [DATA_W-1:0]   arb_data [NUM_REGS];
    logic [NUM_REGS-1:0] arb_we;
    logic [NUM_REGS-1:0] arb_conf;
    logic [DATA_W-1:0]   xfer_val;
    logic                conflict_q, conflict_d, conflict_set;
    logic                ovf_q, ovf_d, ovf_set;
    logic                unf_q, unf_d, unf_set;
    sp_op_e              op;

    // Out-of-range addresses match no entry and therefore read as zero.
    function automatic logic [DATA_W-1:0] bank_read(
        input logic [DATA_W-1:0] bank [NUM_REGS],
        input logic [IDX_W-1:0]  addr
    );
        bank_read = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == IDX_W'(i)) bank_read = bank[i];
        end
    endfunction

    assign op        = sp_op_e'(sp_op);
    assign xfer_val  = bank_read(live_q, xfer_src);
    assign rd_data_a = bank_read(live_q, rd_addr_a);
    assign rd_data_b = bank_read(live_q, rd_addr_b);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_arb
        reg_write_arb #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W),
            .MY_IDX (g)
        ) u_arb (
            .alu_we_i    (alu_we),
            .alu_dst_i   (alu_dst),
            .alu_data_i  (alu_data),
            .mem_we_i    (mem_we),
            .mem_dst_i   (mem_dst),
            .mem_data_i  (mem_data),
            .in_we_i     (in_we),
            .in_dst_i    (in_dst),
            .in_data_i   (in_data),
            .xfer_en_i   (xfer_en),
            .xfer_dst_i  (xfer_dst),
            .xfer_data_i (xfer_val),
            .wr_en_o     (arb_we[g]),
            .wr_data_o   (arb_data[g]),
            .conflict_o  (arb_conf[g])
        );
    end

    always_comb begin
        live_d       = live_q;
        shadow_d     = shadow_q;
        conflict_set = |arb_conf;
        ovf_set      = 1'b0;
        unf_set      = 1'b0;

        for (int i = 0; i < NUM_REGS; i++) begin
            if (arb_we[i]) live_d[i] = arb_data[i];
        end

        // A source write to SP drops any stack operation in the same cycle.
        if (op == SP_PUSH || op == SP_POP) begin
            if (arb_we[IDX_SP]) begin
                conflict_set = 1'b1;
            end else if (op == SP_PUSH) begin
                if (live_q[IDX_SP] == SP_BOT) ovf_set = 1'b1;
                else live_d[IDX_SP] = live_q[IDX_SP] - DATA_W'(1);
            end else begin
                if (live_q[IDX_SP] == SP_TOP) unf_set = 1'b1;
                else live_d[IDX_SP] = live_q[IDX_SP] + DATA_W'(1);
            end
        end

        if (!arb_we[IDX_SR] && sr_flags_we) live_d[IDX_SR][FLAG_W-1:0] = sr_flags;
        if (proc_finish) live_d[IDX_SR][PFF_BIT] = 1'b1;
        if (!arb_we[IDX_BR] && br_clr) live_d[IDX_BR] = '0;

        if (ctx_save) shadow_d = live_q;
        // Restore discards every same-cycle request, including their error side effects.
        if (ctx_restore) begin
            live_d       = shadow_q;
            conflict_set = 1'b0;
            ovf_set      = 1'b0;
            unf_set      = 1'b0;
        end

        conflict_d = conflict_set | (conflict_q & ~err_clr);
        ovf_d      = ovf_set      | (ovf_q      & ~err_clr);
        unf_d      = unf_set      | (unf_q      & ~err_clr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            live_q[IDX_SP] <= SP_TOP;
            conflict_q     <= 1'b0;
            ovf_q          <= 1'b0;
            unf_q          <= 1'b0;
        end else begin
            live_q     <= live_d;
            shadow_q   <= shadow_d;
            conflict_q <= conflict_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign acc          = live_q[IDX_ACC];
    assign sp           = live_q[IDX_SP];
    assign sr           = live_q[IDX_SR];
    assign pff          = live_q[IDX_SR][PFF_BIT];
    assign conflict_err = conflict_q;
    assign sp_ovf       = ovf_q;
    assign sp_unf       = unf_q;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Bench for reg_bank_wb: directed vectors with literal expectations plus a
// per-cycle comparison against a plain behavioural model of the bank.
module tb_reg_bank_wb;

    localparam int NR = 8;
    localparam int IW = 4;   // one spare index bit so index NUM_REGS is reachable

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic alu_we, mem_we, in_we, xfer_en, sr_flags_we, proc_finish, br_clr;
    logic ctx_save, ctx_restore, err_clr;
    logic [IW-1:0] alu_dst, mem_dst, in_dst, xfer_src, xfer_dst, rd_addr_a, rd_addr_b;
    logic [31:0] alu_data, mem_data, in_data;
    logic [2:0] sr_flags;
    logic [1:0] sp_op;
    logic [31:0] rd_data_a, rd_data_b, acc, sp, sr;
    logic pff, conflict_err, sp_ovf, sp_unf;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    logic [31:0] m_reg [NR];
    logic [31:0] m_sh  [NR];
    bit m_conf, m_ovf, m_unf;

    reg_bank_wb #(.DATA_W(32), .NUM_REGS(NR), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset),
        .alu_we(alu_we), .alu_dst(alu_dst), .alu_data(alu_data),
        .mem_we(mem_we), .mem_dst(mem_dst), .mem_data(mem_data),
        .in_we(in_we), .in_dst(in_dst), .in_data(in_data),
        .xfer_en(xfer_en), .xfer_src(xfer_src), .xfer_dst(xfer_dst),
        .sr_flags_we(sr_flags_we), .sr_flags(sr_flags), .proc_finish(proc_finish),
        .br_clr(br_clr), .sp_op(sp_op), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .acc(acc), .sp(sp), .sr(sr), .pff(pff),
        .conflict_err(conflict_err), .sp_ovf(sp_ovf), .sp_unf(sp_unf),
        .err_clr(err_clr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_arr(input logic [31:0] arr [NR], input logic [IW-1:0] a);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < NR; i++) if (a == i) r = arr[i];
        return r;
    endfunction

    // Model: for each register list the requesters, the spec's top-priority one wins.
    task automatic model_step();
        logic [31:0] pre [NR];
        logic [31:0] nxt [NR];
        bit written [NR];
        bit cset, oset, uset;
        int n;
        logic [31:0] v;
        pre = m_reg;
        nxt = m_reg;
        cset = 0; oset = 0; uset = 0;
        for (int d = 0; d < NR; d++) begin
            n = 0;
            v = 0;
            if (alu_we  && alu_dst  == d) begin n++; v = alu_data; end
            if (in_we   && in_dst   == d) begin n++; v = in_data;  end
            if (mem_we  && mem_dst  == d) begin n++; v = mem_data; end
            if (xfer_en && xfer_dst == d) begin n++; v = rd_arr(pre, xfer_src); end
            written[d] = (n > 0);
            if (n > 0) nxt[d] = v;
            if (n > 1) cset = 1;
        end
        if (sp_op == 2'b01 || sp_op == 2'b10) begin
            if (written[3]) cset = 1;
            else if (sp_op == 2'b01) begin
                if (pre[3] == 0) oset = 1; else nxt[3] = pre[3] - 1;
            end else begin
                if (pre[3] == 9497) uset = 1; else nxt[3] = pre[3] + 1;
            end
        end
        if (!written[4] && sr_flags_we) nxt[4] = {pre[4][31:3], sr_flags};
        if (proc_finish) nxt[4] = nxt[4] | 32'h8;
        if (!written[5] && br_clr) nxt[5] = 0;
        if (ctx_restore) begin
            nxt = m_sh;
            cset = 0; oset = 0; uset = 0;
        end
        if (ctx_save) m_sh = pre;
        m_reg  = nxt;
        m_conf = cset || (m_conf && !err_clr);
        m_ovf  = oset || (m_ovf  && !err_clr);
        m_unf  = uset || (m_unf  && !err_clr);
    endtask

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i] = 0;
                m_sh[i]  = 0;
            end
            m_reg[3] = 9497;
            m_conf = 0; m_ovf = 0; m_unf = 0;
        end else begin
            model_step();
        end
        started = 1;
    end

    always @(negedge clock) begin
        if (started) begin
            chk("model_acc", acc, m_reg[0]);
            chk("model_sp", sp, m_reg[3]);
            chk("model_sr", sr, m_reg[4]);
            chk("model_pff", {31'b0, pff}, {31'b0, m_reg[4][3]});
            chk("model_rda", rd_data_a, rd_arr(m_reg, rd_addr_a));
            chk("model_rdb", rd_data_b, rd_arr(m_reg, rd_addr_b));
            chk("model_conf", {31'b0, conflict_err}, {31'b0, m_conf});
            chk("model_ovf", {31'b0, sp_ovf}, {31'b0, m_ovf});
            chk("model_unf", {31'b0, sp_unf}, {31'b0, m_unf});
        end
    end

    task automatic idle();
        alu_we = 0; mem_we = 0; in_we = 0; xfer_en = 0;
        alu_dst = 0; mem_dst = 0; in_dst = 0; xfer_src = 0; xfer_dst = 0;
        alu_data = 0; mem_data = 0; in_data = 0;
        sr_flags_we = 0; sr_flags = 0; proc_finish = 0; br_clr = 0; sp_op = 0;
        ctx_save = 0; ctx_restore = 0; err_clr = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rd_addr_a = 1; rd_addr_b = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        chk("rst_acc", acc, 32'h0);
        chk("rst_sp", sp, 32'd9497);
        chk("rst_conf", {31'b0, conflict_err}, 32'h0);

        alu_we = 1; alu_dst = 1; alu_data = 32'h55; tick();
        chk("alu_x", rd_data_a, 32'h55);
        reset = 1; tick(); reset = 0;
        chk("rst_x", rd_data_a, 32'h0);
        chk("rst_sp2", sp, 32'd9497);

        mem_we = 1; mem_dst = 0; mem_data = 32'hA;
        alu_we = 1; alu_dst = 0; alu_data = 32'hB; tick();
        chk("conf_acc", acc, 32'hA);
        chk("conf_flag", {31'b0, conflict_err}, 32'h1);
        err_clr = 1; tick();
        chk("conf_clr", {31'b0, conflict_err}, 32'h0);

        sp_op = 2'b01; tick();
        chk("push", sp, 32'd9496);
        sp_op = 2'b10; tick();
        chk("pop", sp, 32'd9497);
        sp_op = 2'b10; tick();
        chk("pop_top", sp, 32'd9497);
        chk("unf", {31'b0, sp_unf}, 32'h1);
        in_we = 1; in_dst = 3; in_data = 0; tick();
        sp_op = 2'b01; tick();
        chk("push_min", sp, 32'd0);
        chk("ovf", {31'b0, sp_ovf}, 32'h1);
        err_clr = 1; tick();
        chk("ovf_clr", {31'b0, sp_ovf}, 32'h0);

        sr_flags_we = 1; sr_flags = 3'b101; proc_finish = 1; tick();
        chk("sr_flags", sr, 32'h0D);
        chk("pff", {31'b0, pff}, 32'h1);
        in_we = 1; in_dst = 4; in_data = 0; proc_finish = 1; tick();
        chk("sr_full", sr, 32'h08);

        alu_we = 1; alu_dst = 1; alu_data = 5; tick();
        ctx_save = 1; tick();
        alu_we = 1; alu_dst = 1; alu_data = 9; tick();
        chk("x_9", rd_data_a, 32'd9);
        ctx_restore = 1; alu_we = 1; alu_dst = 1; alu_data = 7; tick();
        chk("restore_x", rd_data_a, 32'd5);

        alu_we = 1; alu_dst = 0; alu_data = 1;
        mem_we = 1; mem_dst = 1; mem_data = 2; tick();
        xfer_en = 1; xfer_src = 0; xfer_dst = 1; tick();
        chk("xfer_x", rd_data_a, 32'd1);
        xfer_en = 1; xfer_src = 1; xfer_dst = 0; tick();
        chk("xfer_acc", acc, 32'd1);
        rd_addr_b = 2;
        xfer_en = 1; xfer_src = 0; xfer_dst = 2;
        alu_we = 1; alu_dst = 0; alu_data = 32'h99; tick();
        chk("xfer_pre_edge", rd_data_b, 32'd1);
        chk("xfer_acc_new", acc, 32'h99);

        rd_addr_a = 8;
        alu_we = 1; alu_dst = 8; alu_data = 32'hDEAD; tick();
        chk("oob_read", rd_data_a, 32'h0);
        chk("oob_acc", acc, 32'h99);

        rd_addr_a = 5;
        alu_we = 1; alu_dst = 5; alu_data = 32'h77; tick();
        br_clr = 1; mem_we = 1; mem_dst = 5; mem_data = 32'h33; tick();
        chk("br_write_wins", rd_data_a, 32'h33);
        br_clr = 1; tick();
        chk("br_clr", rd_data_a, 32'h0);

        sp_op = 2'b01; in_we = 1; in_dst = 3; in_data = 100; tick();
        chk("sp_wr_wins", sp, 32'd100);
        chk("sp_wr_conf", {31'b0, conflict_err}, 32'h1);
        chk("sp_wr_noovf", {31'b0, sp_ovf}, 32'h0);
        err_clr = 1; tick();

        ctx_save = 1; ctx_restore = 1; tick();
        chk("swap_acc", acc, 32'hA);
        ctx_restore = 1; tick();
        chk("swap_back", acc, 32'h99);

        reset = 1; ctx_restore = 1; alu_we = 1; alu_dst = 0; alu_data = 32'h5; tick();
        reset = 0;
        chk("rst_over_restore", acc, 32'h0);
        chk("rst_over_sp", sp, 32'd9497);
        ctx_restore = 1; tick();
        chk("shadow_cleared", sp, 32'd0);

        for (int k = 0; k < 80; k++) begin
            alu_we = ($urandom_range(0, 1) == 1); alu_dst = IW'($urandom_range(0, 8)); alu_data = $urandom;
            mem_we = ($urandom_range(0, 2) == 0); mem_dst = IW'($urandom_range(0, 8)); mem_data = $urandom;
            in_we  = ($urandom_range(0, 2) == 0); in_dst = IW'($urandom_range(0, 8)); in_data = $urandom;
            xfer_en = ($urandom_range(0, 2) == 0);
            xfer_src = IW'($urandom_range(0, 8)); xfer_dst = IW'($urandom_range(0, 8));
            sr_flags_we = ($urandom_range(0, 1) == 1); sr_flags = 3'($urandom);
            proc_finish = ($urandom_range(0, 3) == 0); br_clr = ($urandom_range(0, 3) == 0);
            sp_op = 2'($urandom); err_clr = ($urandom_range(0, 3) == 0);
            ctx_save = ($urandom_range(0, 7) == 0); ctx_restore = ($urandom_range(0, 7) == 0);
            rd_addr_a = IW'($urandom_range(0, 8)); rd_addr_b = IW'($urandom_range(0, 8));
            tick();
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
